fp16_skew_feeder: RTL
=====================

// Module: fp16_skew_feeder
// PURPOSE
//  Upstream operand stage for the tiled FP16 systolic MatMul. Captures one DEPTH x N tile of FP16
//  operands row by row over a valid/ready input. Replays the tile into the array with diagonal skew:
//  lane i is delayed i cycles. Tags each emitted operand with a zero flag so the array can skip the MAC.
//  Keeps a saturating count of zero operands for the skip statistics.
// PARAMETERS
//  N      4   lanes (array rows fed); each lane carries one FP16 word per beat
//  DEPTH  4   rows per tile (K dimension of one tile)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      input row valid
//  in_ready    out  1      input row accepted when in_valid & in_ready at a clk edge
//  in_data     in   N*16   row; lane i = in_data[16*i+15:16*i], FP16
//  stats_clr   in   1      synchronous clear of zero_count
//  out_valid   out  N      per-lane operand valid (skewed)
//  out_data    out  N*16   per-lane operand; lane i = out_data[16*i+15:16*i]
//  out_zero    out  N      per-lane zero flag, qualified by out_valid
//  tile_done   out  1      one-cycle pulse on the final drain beat
//  busy        out  1      high in FILL or DRAIN
//  zero_count  out  32     total zero operands emitted, saturating
// BEHAVIOUR
//  Reset (async): state=IDLE, row/drain counters=0, in_ready=1, out_valid=0, out_data=0,
//   out_zero=0, tile_done=0, busy=0, zero_count=0.
//   Tile buffer contents are don't-care after reset. A partially filled or draining tile is discarded.
//  FSM states: IDLE, FILL, DRAIN.
//  - IDLE: in_ready=1. An accepted row is written to buffer row 0, row counter becomes 1, state goes to FILL.
//    If DEPTH==1, state goes straight to DRAIN.
//  - FILL: in_ready=1. An accepted row is written at the row counter, which then increments.
//    in_valid gaps are allowed; state and counter hold.
//    The edge accepting row DEPTH-1 moves to DRAIN with drain counter t=0.
//  - DRAIN: in_ready=0. Runs DEPTH+N-1 beats, t=0..DEPTH+N-2, one per cycle, with no stalls.
//    Outputs are registered: beat t is visible during the cycle after the edge where the counter equals t.
//    First beat is visible 2 edges after the last row is accepted.
//    At beat t, lane i: r=t-i. If 0<=r<DEPTH then out_valid[i]=1 and out_data lane i=buf[r][i];
//    otherwise out_valid[i]=0 and lane data=0.
//    tile_done=1 only during beat DEPTH+N-2. The next edge returns to IDLE and clears out_valid,
//    out_zero and tile_done. in_ready is 1 again from that point.
//  Zero detect: out_zero[i] = out_valid[i] & (lane[14:0]==0). Both +0 (0x0000) and -0 (0x8000) count as zero.
//    Subnormals (nonzero mantissa) are not zero.
//  zero_count: on each edge where a beat is presented, adds popcount(out_zero) of that beat.
//    Saturates at 32'hFFFF_FFFF, with no wrap.
//    stats_clr=1 sets it to 0 on that edge; clear wins over a coincident increment.
//  busy = (state != IDLE). Only one tile is in flight; no new row is accepted until the drain completes.
//  Data is passed through bit-exact; no FP arithmetic in this block.
// TESTING
//  1. N=4, DEPTH=4, rows k=0..3 with lane i = 16'h3C00+16*k+i, streamed back-to-back.
//     -> 7 drain beats. Beat 0: only lane0=0x3C00. Beat 3: all lanes valid, lane i=buf[3-i][i].
//     Beat 6: only lane3=0x3C33. tile_done on beat 6 only.
//  2. Tile containing 0x0000 x3, 0x8000 x2, 0x0001 x1, rest nonzero.
//     -> out_zero high on exactly 5 lane-beats; zero_count=5 after the drain; 0x0001 is not flagged.
//  3. in_valid toggled 1,0,0,1,1,0,1 during fill.
//     -> exactly 4 rows captured in order; DRAIN entered only after the 4th accept;
//     in_ready=0 for all 7 drain beats.
//  4. Assert rst mid-DRAIN (beat 3).
//     -> all outputs 0 and in_ready=1 immediately, with no clock edge needed;
//     next tile drains correctly from beat 0.
//  5. stats_clr=1 on the edge a beat with 2 zero flags is counted.
//     -> zero_count=0 after that edge; subsequent beats count from 0.
//  6. Two tiles back-to-back with in_valid held high.
//     -> second tile's row 0 is accepted on the edge after tile_done; no row is lost or duplicated.

Source files
------------

// File: rtl/fp16_skew_feeder.sv
// rtl/fp16_skew_feeder.sv - captures a DEPTH x N FP16 tile and replays it with per-lane diagonal skew
// Lane i of the replay lags lane 0 by i beats; each emitted word carries a zero flag for MAC skipping.
module fp16_skew_feeder #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*16-1:0]   in_data,
    input  logic              stats_clr,
    output logic [N-1:0]      out_valid,
    output logic [N*16-1:0]   out_data,
    output logic [N-1:0]      out_zero,
    output logic              tile_done,
    output logic              busy,
    output logic [31:0]       zero_count
);
    localparam int BEATS = DEPTH + N - 1;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                   state;
    logic [CW-1:0]            row_cnt;
    logic [CW-1:0]            t_cnt;
    logic [DEPTH*N*16-1:0]    tile_mem;
    logic [N-1:0]             nxt_valid;
    logic [N*16-1:0]          nxt_data;
    logic [N-1:0]             nxt_zero;
    logic [32:0]              zsum;

    assign in_ready = (state != DRAIN);
    assign busy     = (state != IDLE);

    wire accept = in_valid && in_ready;

    // Tile storage needs no reset: it is always fully rewritten before a drain.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                tile_mem[(int'(row_cnt) * N + i) * 16 +: 16] <= in_data[16*i +: 16];
            end
        end
    end

    // Beat t, lane i replays tile row t-i when that row exists.
    always_comb begin
        nxt_valid = '0;
        nxt_data  = '0;
        nxt_zero  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(t_cnt) >= i && int'(t_cnt) - i < DEPTH) begin
                nxt_valid[i]        = 1'b1;
                nxt_data[16*i +: 16] = tile_mem[((int'(t_cnt) - i) * N + i) * 16 +: 16];
                nxt_zero[i]         = (tile_mem[((int'(t_cnt) - i) * N + i) * 16 +: 15] == 15'd0);
            end
        end
    end

    always_comb begin
        zsum = {1'b0, zero_count};
        for (int i = 0; i < N; i++) begin
            zsum = zsum + 33'(out_zero[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            t_cnt      <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            out_zero   <= '0;
            tile_done  <= 1'b0;
            zero_count <= '0;
        end else begin
            if (stats_clr) begin
                zero_count <= '0;
            end else if (zsum[32]) begin
                zero_count <= 32'hFFFF_FFFF;
            end else begin
                zero_count <= zsum[31:0];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= (DEPTH == 1) ? DRAIN : FILL;
                        row_cnt <= (DEPTH == 1) ? '0 : CW'(1);
                        t_cnt   <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (row_cnt == CW'(DEPTH - 1)) begin
                            state   <= DRAIN;
                            row_cnt <= '0;
                            t_cnt   <= '0;
                        end else begin
                            row_cnt <= row_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // One extra count past the last beat retires the outputs before reopening input.
                    if (t_cnt == CW'(BEATS)) begin
                        state     <= IDLE;
                        t_cnt     <= '0;
                        out_valid <= '0;
                        out_data  <= '0;
                        out_zero  <= '0;
                        tile_done <= 1'b0;
                    end else begin
                        out_valid <= nxt_valid;
                        out_data  <= nxt_data;
                        out_zero  <= nxt_zero;
                        tile_done <= (t_cnt == CW'(BEATS - 1));
                        t_cnt     <= t_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
